// File: rtl/fp16_mac_pkg.sv
// Shared FP16 field layout, operand-pair struct and sequencer state encoding.
// Imported by the sequencer, its operand FIFO wrapper and the bus interface.
package fp16_mac_pkg;

  localparam int FP16_W = 16;
  localparam int EXP_W  = 5;
  localparam int MAN_W  = 10;

  localparam logic [EXP_W-1:0]  EXP_MAX   = 5'h1F;
  localparam logic [FP16_W-1:0] FP16_ZERO = 16'h0000;

  typedef logic [FP16_W-1:0] fp16_t;

  typedef struct packed {
    fp16_t a;
    fp16_t b;
  } op_pair_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_DRAIN,
    S_HOLD
  } seq_state_e;

  // All-ones exponent covers both Inf and NaN encodings.
  function automatic logic fp16_is_special(input fp16_t x);
    return x[MAN_W +: EXP_W] == EXP_MAX;
  endfunction

endpackage

// File: rtl/fp16_mac_sequencer_if.sv
// Job, operand, MAC and result signals of the sequencer bundled as one bus.
// master = sequencer side, slave = job/operand source, MAC and result consumer side.
interface fp16_mac_sequencer_if #(
  parameter int LEN_W = 8
);
  import fp16_mac_pkg::*;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [LEN_W-1:0] cmd_len;

  logic             op_valid;
  logic             op_ready;
  fp16_t            op_a;
  fp16_t            op_b;

  fp16_t            mac_numA;
  fp16_t            mac_numB;
  logic             mac_clr;
  fp16_t            mac_acc;

  logic             res_valid;
  logic             res_ready;
  fp16_t            res_data;
  logic             res_special;

  modport master (
    input  cmd_valid, cmd_len, op_valid, op_a, op_b, mac_acc, res_ready,
    output cmd_ready, op_ready, mac_numA, mac_numB, mac_clr,
           res_valid, res_data, res_special
  );

  modport slave (
    output cmd_valid, cmd_len, op_valid, op_a, op_b, mac_acc, res_ready,
    input  cmd_ready, op_ready, mac_numA, mac_numB, mac_clr,
           res_valid, res_data, res_special
  );

endinterface

// File: rtl/mac_operand_fifo.sv
// Generic synchronous FIFO: write data visible on pop_dat the cycle after push.
// push is ignored while full, pop while empty; simultaneous push/pop allowed when not full.
module mac_operand_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             Asynch_Reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Extra pointer MSB tells full from empty when the index bits match.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign pop_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge Asynch_Reset) begin
    if (Asynch_Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop && !empty) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/fp16_mac_sequencer.sv
// Clears the MAC, streams cmd_len buffered FP16 pairs, drains MAC_LAT+1 zero cycles, returns ACC_Result.
// Optional macro FP16_SPECIAL_FLAG_EN adds a sticky NaN/Inf flag reported on res_special.
module fp16_mac_sequencer
  import fp16_mac_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 8,
  parameter int MAC_LAT    = 3
) (
  input  logic                 clk,
  input  logic                 Asynch_Reset,
  fp16_mac_sequencer_if.master bus
);

  localparam int                 DRAIN_W    = $clog2(MAC_LAT + 2);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(MAC_LAT);
  localparam logic [DRAIN_W-1:0] DRAIN_ONE  = DRAIN_W'(1);
  localparam logic [LEN_W-1:0]   LEN_ONE    = LEN_W'(1);

  seq_state_e         state;
  logic [LEN_W-1:0]   rem;
  logic [DRAIN_W-1:0] drain_cnt;
  fp16_t              num_a_q;
  fp16_t              num_b_q;
  fp16_t              res_data_q;
  logic               mac_clr_q;
  logic               res_valid_q;

  op_pair_t           push_pair;
  op_pair_t           pop_pair;
  logic               fifo_full;
  logic               fifo_empty;
  logic               pop;
  logic               drain_done;

  assign push_pair  = '{a: bus.op_a, b: bus.op_b};
  assign pop        = (state == S_STREAM) && !fifo_empty;
  assign drain_done = (state == S_DRAIN) && (drain_cnt == '0);

  mac_operand_fifo #(
    .WIDTH ($bits(op_pair_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .Asynch_Reset (Asynch_Reset),
    .push         (bus.op_valid),
    .push_dat     (push_pair),
    .pop          (pop),
    .pop_dat      (pop_pair),
    .full         (fifo_full),
    .empty        (fifo_empty)
  );

  // Operands default to zero every cycle so only real pops touch the accumulator.
  always_ff @(posedge clk or posedge Asynch_Reset) begin
    if (Asynch_Reset) begin
      state       <= S_IDLE;
      rem         <= '0;
      drain_cnt   <= '0;
      num_a_q     <= FP16_ZERO;
      num_b_q     <= FP16_ZERO;
      mac_clr_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= FP16_ZERO;
    end else begin
      mac_clr_q <= 1'b0;
      num_a_q   <= FP16_ZERO;
      num_b_q   <= FP16_ZERO;
      case (state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            rem       <= bus.cmd_len;
            mac_clr_q <= 1'b1;
            state     <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          drain_cnt <= DRAIN_LAST;
          state     <= (rem == '0) ? S_DRAIN : S_STREAM;
        end
        S_STREAM: begin
          if (pop) begin
            num_a_q <= pop_pair.a;
            num_b_q <= pop_pair.b;
            rem     <= rem - LEN_ONE;
            if (rem == LEN_ONE) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (drain_done) begin
            res_data_q  <= bus.mac_acc;
            res_valid_q <= 1'b1;
            state       <= S_HOLD;
          end else begin
            drain_cnt <= drain_cnt - DRAIN_ONE;
          end
        end
        S_HOLD: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef FP16_SPECIAL_FLAG_EN
  logic special_flag;
  logic res_special_q;

  always_ff @(posedge clk or posedge Asynch_Reset) begin
    if (Asynch_Reset) begin
      special_flag  <= 1'b0;
      res_special_q <= 1'b0;
    end else begin
      if (state == S_CLEAR) begin
        special_flag <= 1'b0;
      end else if (pop && (fp16_is_special(pop_pair.a) || fp16_is_special(pop_pair.b))) begin
        special_flag <= 1'b1;
      end
      if (drain_done) res_special_q <= special_flag;
    end
  end

  assign bus.res_special = res_special_q;
`else
  assign bus.res_special = 1'b0;
`endif

  assign bus.cmd_ready = (state == S_IDLE);
  assign bus.op_ready  = !fifo_full;
  assign bus.mac_numA  = num_a_q;
  assign bus.mac_numB  = num_b_q;
  assign bus.mac_clr   = mac_clr_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;

endmodule

// File: tb/tb_fp16_mac_sequencer.sv
// Directed bench for fp16_mac_sequencer against a behavioural 3-stage FP16 MAC model.
// Build with FP16_SPECIAL_FLAG_EN defined to expect the NaN/Inf flag on res_special.
module tb_fp16_mac_sequencer;
  import fp16_mac_pkg::*;

  localparam int LEN_W      = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int MAC_LAT    = 3;

`ifdef FP16_SPECIAL_FLAG_EN
  localparam logic EXP_SPECIAL = 1'b1;
`else
  localparam logic EXP_SPECIAL = 1'b0;
`endif

  logic clk = 1'b0;
  logic Asynch_Reset;
  always #5 clk = ~clk;

  fp16_mac_sequencer_if #(.LEN_W(LEN_W)) bus ();

  fp16_mac_sequencer #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .LEN_W      (LEN_W),
    .MAC_LAT    (MAC_LAT)
  ) dut (
    .clk          (clk),
    .Asynch_Reset (Asynch_Reset),
    .bus          (bus)
  );

  // ---------------- behavioural MAC ----------------
  function automatic real h2r(input logic [15:0] h);
    real r;
    int  e;
    e = int'(h[14:10]);
    if (e == 31) return h[15] ? -1.0e30 : 1.0e30;
    r = real'(h[9:0]) / 1024.0;
    if (e == 0) e = 1;
    else        r = r + 1.0;
    for (int i = e; i < 15; i++) r = r / 2.0;
    for (int i = 15; i < e; i++) r = r * 2.0;
    return h[15] ? -r : r;
  endfunction

  function automatic logic [15:0] r2h(input real r);
    logic       s;
    real        a;
    int         e;
    logic [9:0] man;
    s = (r < 0.0);
    a = s ? -r : r;
    if (a == 0.0) return 16'h0000;
    if (a >= 65520.0) return {s, 5'h1F, 10'h000};
    e = 15;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0 && e > 1) begin a = a * 2.0; e--; end
    if (a < 1.0) begin
      man = 10'(int'(a * 1024.0));
      e   = 0;
    end else begin
      man = 10'(int'((a - 1.0) * 1024.0));
    end
    return {s, 5'(e), man};
  endfunction

  real p1, p2, acc_r;
  always @(posedge clk or posedge Asynch_Reset) begin
    if (Asynch_Reset || bus.mac_clr) begin
      p1    <= 0.0;
      p2    <= 0.0;
      acc_r <= 0.0;
    end else begin
      p1    <= h2r(bus.mac_numA) * h2r(bus.mac_numB);
      p2    <= p1;
      acc_r <= acc_r + p2;
    end
  end
  assign bus.mac_acc = r2h(acc_r);

  // ---------------- checking helpers ----------------
  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push(input logic [15:0] a, input logic [15:0] b);
    bus.op_valid = 1'b1;
    bus.op_a     = a;
    bus.op_b     = b;
    tick();
    bus.op_valid = 1'b0;
  endtask

  task automatic start_job(input string tag, input logic [LEN_W-1:0] len, output int t0);
    chk1({tag, "_cmd_ready_idle"}, bus.cmd_ready, 1'b1);
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = len;
    tick();
    bus.cmd_valid = 1'b0;
    t0 = cyc;
    chk1({tag, "_mac_clr"}, bus.mac_clr, 1'b1);
    chk1({tag, "_cmd_ready_busy"}, bus.cmd_ready, 1'b0);
  endtask

  task automatic wait_res(input string tag, input int t0, input int exp_lat,
                          input logic [15:0] exp_data);
    while (bus.res_valid !== 1'b1 && (cyc - t0) < 60) tick();
    chki({tag, "_latency"}, cyc - t0, exp_lat);
    chk16({tag, "_res_data"}, bus.res_data, exp_data);
  endtask

  task automatic release_res(input string tag);
    bus.res_ready = 1'b1;
    tick();
    chk1({tag, "_res_released"}, bus.res_valid, 1'b0);
    chk1({tag, "_back_idle"}, bus.cmd_ready, 1'b1);
  endtask

  task automatic chk_reset_state(input string tag);
    chk16({tag, "_numA"}, bus.mac_numA, 16'h0000);
    chk16({tag, "_numB"}, bus.mac_numB, 16'h0000);
    chk1({tag, "_mac_clr"}, bus.mac_clr, 1'b0);
    chk1({tag, "_res_valid"}, bus.res_valid, 1'b0);
    chk16({tag, "_res_data"}, bus.res_data, 16'h0000);
    chk1({tag, "_res_special"}, bus.res_special, 1'b0);
    chk1({tag, "_cmd_ready"}, bus.cmd_ready, 1'b1);
    chk1({tag, "_op_ready"}, bus.op_ready, 1'b1);
  endtask

  // ---------------- directed sequence ----------------
  int t0;

  initial begin
    Asynch_Reset  = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_len   = '0;
    bus.op_valid  = 1'b0;
    bus.op_a      = 16'h0000;
    bus.op_b      = 16'h0000;
    bus.res_ready = 1'b1;
    tick();
    tick();
    chk_reset_state("reset");
    Asynch_Reset = 1'b0;
    tick();

    // 1: three back-to-back pairs, 1*2 + 1*1 + 2*2 = 7.0
    push(16'h3C00, 16'h4000);
    push(16'h3C00, 16'h3C00);
    push(16'h4000, 16'h4000);
    start_job("t1", 8'd3, t0);
    tick();
    tick();
    chk16("t1_first_numA", bus.mac_numA, 16'h3C00);
    chk16("t1_first_numB", bus.mac_numB, 16'h4000);
    wait_res("t1", t0, 1 + 3 + MAC_LAT + 1, 16'h4700);
    chk1("t1_special", bus.res_special, 1'b0);
    release_res("t1");

    // 2: FIFO runs dry for two cycles after the first pair
    push(16'h3C00, 16'h4000);
    start_job("t2", 8'd3, t0);
    tick();
    tick();
    tick();
    chk16("t2_bubble_numA", bus.mac_numA, 16'h0000);
    bus.op_valid = 1'b1;
    bus.op_a     = 16'h3C00;
    bus.op_b     = 16'h3C00;
    tick();
    bus.op_a     = 16'h4000;
    bus.op_b     = 16'h4000;
    tick();
    bus.op_valid = 1'b0;
    wait_res("t2", t0, 1 + 3 + MAC_LAT + 1 + 2, 16'h4700);
    release_res("t2");

    // 3: empty job returns the cleared accumulator
    start_job("t3", 8'd0, t0);
    wait_res("t3", t0, 1 + MAC_LAT + 1, 16'h0000);
    release_res("t3");

    // 4: result held while consumer stalls; FIFO keeps filling to depth
    bus.res_ready = 1'b0;
    push(16'h4000, 16'h4000);
    start_job("t4", 8'd1, t0);
    wait_res("t4", t0, 1 + 1 + MAC_LAT + 1, 16'h4400);
    for (int i = 0; i < 5; i++) begin
      bus.op_valid = 1'b1;
      bus.op_a     = 16'h3C00;
      bus.op_b     = 16'h3C00;
      tick();
      chk1("t4_hold_valid", bus.res_valid, 1'b1);
      chk16("t4_hold_data", bus.res_data, 16'h4400);
      chk1("t4_hold_cmd_ready", bus.cmd_ready, 1'b0);
      chk1("t4_op_ready", bus.op_ready, (i < FIFO_DEPTH - 1));
    end
    bus.op_valid = 1'b0;
    release_res("t4");

    // 5: reset mid-stream, then repeat job 1
    start_job("t5", 8'd3, t0);
    tick();
    tick();
    chk16("t5_streaming_numA", bus.mac_numA, 16'h3C00);
    Asynch_Reset = 1'b1;
    #2;
    chk_reset_state("t5_reset");
    tick();
    Asynch_Reset = 1'b0;
    tick();
    push(16'h3C00, 16'h4000);
    push(16'h3C00, 16'h3C00);
    push(16'h4000, 16'h4000);
    start_job("t5_rerun", 8'd3, t0);
    wait_res("t5_rerun", t0, 1 + 3 + MAC_LAT + 1, 16'h4700);
    release_res("t5_rerun");

    // 6: Inf operand, then a clean job
    push(16'h7C00, 16'h3C00);
    start_job("t6", 8'd1, t0);
    wait_res("t6", t0, 1 + 1 + MAC_LAT + 1, 16'h7C00);
    chk1("t6_special", bus.res_special, EXP_SPECIAL);
    release_res("t6");
    push(16'h3C00, 16'h3C00);
    start_job("t6_clean", 8'd1, t0);
    wait_res("t6_clean", t0, 1 + 1 + MAC_LAT + 1, 16'h3C00);
    chk1("t6_clean_special", bus.res_special, 1'b0);
    release_res("t6_clean");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
